// File: rtl/uart_pkg.sv
// Shared constants for the uart_tx launch path: byte width and launch FSM encoding.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACT  = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_DRAIN     = 2'd3
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty; flags update the cycle after a push or pop.
// A push while full is dropped (checked against the registered flag) and flagged by a one-cycle overflow pulse.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int  DEPTH = 16,
   parameter int  DW    = BYTE_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] push_dat_i,
   input  logic          pop_i,
   output logic [DW-1:0] pop_dat_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o,
   output logic          overflow_o
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          full_q, empty_q, overflow_q;
   logic          push_ok, pop_ok;

   assign push_ok = push_i & ~full_q;
   assign pop_ok  = pop_i & ~empty_q;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         full_q     <= (count_d == FULL_CNT);
         empty_q    <= (count_d == '0);
         overflow_q <= push_i & full_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign pop_dat_o  = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx one single-cycle Dv pulse at a time, honouring its Active/Done handshake.
// Define UART_TX_FIFO_STATS_EN to add saturating sent/dropped byte counters.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              i_Clock,
   input  logic              i_Reset,
   input  logic              i_Wr_Dv,
   input  logic [BYTE_W-1:0] i_Wr_Byte,
   output logic              o_Full,
   output logic              o_Empty,
   output logic [AW:0]       o_Count,
   output logic              o_Overflow,
   output logic              o_Tx_Dv,
   output logic [BYTE_W-1:0] o_Tx_Byte,
   input  logic              i_Tx_Active,
   input  logic              i_Tx_Done,
   output logic              o_Busy
`ifdef UART_TX_FIFO_STATS_EN
   ,
   output logic [15:0]       o_Sent_Cnt,
   output logic [15:0]       o_Drop_Cnt
`endif
);

   state_e            state_q;
   logic              tx_dv_q;
   logic [BYTE_W-1:0] tx_byte_q;
   logic [BYTE_W-1:0] head_dat;
   logic              fifo_empty;
   logic              launch;

   sync_fifo #(
      .DEPTH (DEPTH),
      .DW    (BYTE_W)
   ) u_fifo (
      .clk_i      (i_Clock),
      .rst_i      (i_Reset),
      .push_i     (i_Wr_Dv),
      .push_dat_i (i_Wr_Byte),
      .pop_i      (launch),
      .pop_dat_o  (head_dat),
      .full_o     (o_Full),
      .empty_o    (fifo_empty),
      .count_o    (o_Count),
      .overflow_o (o_Overflow)
   );

   // uart_tx has no reset, so after our reset it may still be mid-frame: require both Active and Done low.
   assign launch = (state_q == ST_IDLE) & ~fifo_empty & ~i_Tx_Active & ~i_Tx_Done;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= '0;
      end else begin
         tx_dv_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (launch) begin
                  tx_byte_q <= head_dat;
                  tx_dv_q   <= 1'b1;
                  state_q   <= ST_WAIT_ACT;
               end
            end
            ST_WAIT_ACT:  if (i_Tx_Active) state_q <= ST_WAIT_DONE;
            ST_WAIT_DONE: if (i_Tx_Done)   state_q <= ST_DRAIN;
            ST_DRAIN:     if (!i_Tx_Done)  state_q <= ST_IDLE;
            default:      state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_Tx_Dv   = tx_dv_q;
   assign o_Tx_Byte = tx_byte_q;
   assign o_Empty   = fifo_empty;
   assign o_Busy    = (state_q != ST_IDLE) | ~fifo_empty;

`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0] sent_cnt_q, drop_cnt_q;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         sent_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (state_q == ST_WAIT_DONE && i_Tx_Done && sent_cnt_q != 16'hFFFF)
            sent_cnt_q <= sent_cnt_q + 1'b1;
         if (i_Wr_Dv && o_Full && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   assign o_Sent_Cnt = sent_cnt_q;
   assign o_Drop_Cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (DEPTH=4) with a behavioural uart_tx (4 clocks per bit) and a byte scoreboard.
module tb_uart_tx_fifo;

   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam int CPB   = 4;

   logic          clk = 1'b0;
   logic          rst, wr_dv;
   logic [7:0]    wr_byte;
   logic          full, empty, ovf, tx_dv, busy;
   logic [AW:0]   count;
   logic [7:0]    tx_byte;
   logic          tx_active, tx_done;
   logic          m_active, m_done, m_serial, stall;
`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0]   sent_cnt, drop_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fall_cyc = 0;
   logic [7:0] exp_q[$];
   int         dv_cyc_q[$];
   int         gap_q[$];
   bit         serial_q[$];
   logic       prev_done = 1'b0;
   logic       prev_dv = 1'b0;
   logic [7:0] mon_exp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign tx_active = m_active | stall;
   assign tx_done   = m_done;

   uart_tx_fifo #(.DEPTH(DEPTH)) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Wr_Dv     (wr_dv),
      .i_Wr_Byte   (wr_byte),
      .o_Full      (full),
      .o_Empty     (empty),
      .o_Count     (count),
      .o_Overflow  (ovf),
      .o_Tx_Dv     (tx_dv),
      .o_Tx_Byte   (tx_byte),
      .i_Tx_Active (tx_active),
      .i_Tx_Done   (tx_done),
      .o_Busy      (busy)
`ifdef UART_TX_FIFO_STATS_EN
      ,
      .o_Sent_Cnt  (sent_cnt),
      .o_Drop_Cnt  (drop_cnt)
`endif
   );

   // Behavioural uart_tx: samples Dv on a clock edge, Active for 10 bit times, then Done for 2 cycles.
   initial begin
      m_active = 1'b0; m_done = 1'b0; m_serial = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_dv === 1'b1) begin
            logic [9:0] frame;
            frame = {1'b1, tx_byte, 1'b0};
            @(posedge clk); #1;
            m_active = 1'b1;
            for (int i = 0; i < 10; i++) begin
               m_serial = frame[i];
               serial_q.push_back(frame[i]);
               repeat (CPB) begin @(posedge clk); #1; end
            end
            m_active = 1'b0; m_done = 1'b1; m_serial = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            m_done = 1'b0;
         end
      end
   end

   // Launch monitor: every Dv must be one cycle wide, hit an idle transmitter, and carry the next expected byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_done && !tx_done) fall_cyc = cyc;
         if (tx_dv === 1'b1) begin
            checks++;
            if (prev_dv === 1'b1) begin
               errors++; $display("FAIL dv_width: Dv high two cycles in a row at cycle %0d", cyc);
            end
            checks++;
            if (tx_active !== 1'b0 || tx_done !== 1'b0) begin
               errors++; $display("FAIL launch_busy: active=%b done=%b at cycle %0d", tx_active, tx_done, cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL unexpected_launch: byte %h with nothing expected", tx_byte);
            end else begin
               mon_exp = exp_q.pop_front();
               if (tx_byte !== mon_exp) begin
                  errors++; $display("FAIL launch_byte: got %h expected %h", tx_byte, mon_exp);
               end
            end
            dv_cyc_q.push_back(cyc);
            gap_q.push_back(cyc - fall_cyc);
         end
      end
      prev_done = tx_done;
      prev_dv   = tx_dv;
   end

   task automatic wait_idle(input int budget, output bit ok);
      int k = 0;
      while ((busy !== 1'b0 || tx_active !== 1'b0 || tx_done !== 1'b0 || exp_q.size() != 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      ok = (k < budget);
   endtask

   task automatic test_reset;
      rst = 1'b1; wr_dv = 1'b0; wr_byte = 8'h00; stall = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({empty, full, count, ovf, busy} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_flags: empty=%b full=%b count=%0d ovf=%b busy=%b, need 1 0 0 0 0",
                            empty, full, count, ovf, busy);
      end
      checks++;
      if ({tx_dv, tx_byte} !== 9'h000) begin
         errors++; $display("FAIL reset_tx: dv=%b byte=%h, need 0 00", tx_dv, tx_byte);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      int n;
      bit ok;
      int exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      serial_q.delete(); dv_cyc_q.delete();
      exp_q.push_back(8'hA5);
      n = cyc;
      wr_dv = 1'b1; wr_byte = 8'hA5;
      @(negedge clk); wr_dv = 1'b0;
      checks++;
      if (count !== 3'd1) begin
         errors++; $display("FAIL single_count1: count=%0d need 1", count);
      end
      @(negedge clk);
      checks++;
      if (tx_dv !== 1'b1 || tx_byte !== 8'hA5 || cyc != n + 2) begin
         errors++; $display("FAIL single_dv: dv=%b byte=%h cycle offset %0d, need 1 A5 2", tx_dv, tx_byte, cyc - n);
      end
      checks++;
      if (count !== 3'd0) begin
         errors++; $display("FAIL single_count0: count=%0d need 0", count);
      end
      @(negedge clk);
      checks++;
      if (tx_active !== 1'b1 || tx_dv !== 1'b0) begin
         errors++; $display("FAIL single_active: active=%b dv=%b, need 1 0", tx_active, tx_dv);
      end
      wait_idle(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout: block never went idle"); end
      checks++;
      if (serial_q.size() != 10) begin
         errors++; $display("FAIL single_serial_len: %0d bits, need 10", serial_q.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (int'(serial_q[i]) != exp_bits[i]) begin
               errors++; $display("FAIL single_serial_bit%0d: got %0d need %0d", i, serial_q[i], exp_bits[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      dv_cyc_q.delete(); gap_q.delete();
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(8'(i));
         wr_dv = 1'b1; wr_byte = 8'(i);
         @(negedge clk);
      end
      wr_dv = 1'b0;
      wait_idle(600, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_timeout: block never went idle"); end
      checks++;
      if (dv_cyc_q.size() != 4) begin
         errors++; $display("FAIL b2b_frames: %0d launches, need 4", dv_cyc_q.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (gap_q[i] != 2) begin
               errors++; $display("FAIL b2b_gap%0d: Dv %0d cycles after Done fell, need 2", i, gap_q[i]);
            end
         end
      end
      checks++;
      if (cyc != fall_cyc + 1) begin
         errors++; $display("FAIL b2b_busy: Busy fell %0d cycles after Done fell, need 1", cyc - fall_cyc);
      end
   endtask

   task automatic test_overflow_and_write_pop;
      logic [7:0] b [6];
      int ovf_cnt = 0;
      bit ok;
      dv_cyc_q.delete();
      stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b[i] = 8'($urandom);
         if (i < 4) exp_q.push_back(b[i]);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (count !== 3'((i < 4) ? i : 4) || full !== (i >= 4)) begin
            errors++; $display("FAIL ovf_fill%0d: count=%0d full=%b", i, count, full);
         end
         if (ovf === 1'b1) ovf_cnt++;
         wr_dv = 1'b1; wr_byte = b[i];
      end
      @(negedge clk); wr_dv = 1'b0;
      if (ovf === 1'b1) ovf_cnt++;
      checks++;
      if (ovf_cnt != 2 || count !== 3'd4 || full !== 1'b1) begin
         errors++; $display("FAIL ovf_result: pulses=%0d count=%0d full=%b, need 2 4 1", ovf_cnt, count, full);
      end
      // Release the stall and write in the very cycle the head is popped.
      @(negedge clk);
      stall = 1'b0; wr_dv = 1'b1; wr_byte = 8'hEE;
      @(negedge clk); wr_dv = 1'b0;
      checks++;
      if (ovf !== 1'b1 || count !== 3'd3) begin
         errors++; $display("FAIL write_pop: ovf=%b count=%0d, need 1 3", ovf, count);
      end
      wait_idle(800, ok);
      checks++;
      if (!ok || dv_cyc_q.size() != 4) begin
         errors++; $display("FAIL ovf_drain: ok=%0d launches=%0d, need 1 4", ok, dv_cyc_q.size());
      end
   endtask

   task automatic test_reset_mid_frame;
      int k = 0;
      bit ok;
      logic [7:0] nb;
      for (int i = 0; i < 4; i++) begin
         nb = 8'($urandom);
         exp_q.push_back(nb);
         wr_dv = 1'b1; wr_byte = nb;
         @(negedge clk);
      end
      wr_dv = 1'b0;
      while (m_active !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      repeat (10) @(negedge clk);
      checks++;
      if (k >= 100 || count !== 3'd3) begin
         errors++; $display("FAIL mid_setup: wait=%0d count=%0d, need <100 3", k, count);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (empty !== 1'b1 || tx_dv !== 1'b0 || count !== 3'd0) begin
         errors++; $display("FAIL mid_reset: empty=%b dv=%b count=%0d, need 1 0 0", empty, tx_dv, count);
      end
      exp_q.delete(); dv_cyc_q.delete(); gap_q.delete();
      rst = 1'b0;
      @(negedge clk);
      nb = 8'($urandom);
      exp_q.push_back(nb);
      wr_dv = 1'b1; wr_byte = nb;
      @(negedge clk); wr_dv = 1'b0;
      wait_idle(400, ok);
      checks++;
      if (!ok || dv_cyc_q.size() != 1) begin
         errors++; $display("FAIL mid_relaunch: ok=%0d launches=%0d, need 1 1", ok, dv_cyc_q.size());
      end else begin
         checks++;
         if (gap_q[0] != 1) begin
            errors++; $display("FAIL mid_gap: launch %0d cycles after Done fell, need 1", gap_q[0]);
         end
      end
   endtask

   task automatic test_random;
      bit ok;
      int len;
      logic [7:0] nb;
      for (int it = 0; it < 6; it++) begin
         dv_cyc_q.delete();
         len = $urandom_range(1, DEPTH);
         for (int i = 0; i < len; i++) begin
            nb = 8'($urandom);
            exp_q.push_back(nb);
            wr_dv = 1'b1; wr_byte = nb;
            @(negedge clk);
            wr_dv = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wait_idle(800, ok);
         checks++;
         if (!ok || dv_cyc_q.size() != len) begin
            errors++; $display("FAIL random%0d: ok=%0d launches=%0d need %0d", it, ok, dv_cyc_q.size(), len);
         end
      end
   endtask

   task automatic test_stats;
      bit ok;
      logic [7:0] nb;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; stall = 1'b1;
      dv_cyc_q.delete();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         nb = 8'($urandom);
         if (i < 4) exp_q.push_back(nb);
         wr_dv = 1'b1; wr_byte = nb;
      end
      @(negedge clk); wr_dv = 1'b0; stall = 1'b0;
      wait_idle(800, ok);
      nb = 8'($urandom);
      exp_q.push_back(nb);
      wr_dv = 1'b1; wr_byte = nb;
      @(negedge clk); wr_dv = 1'b0;
      wait_idle(400, ok);
      checks++;
      if (!ok || dv_cyc_q.size() != 5) begin
         errors++; $display("FAIL stats_launches: ok=%0d launches=%0d, need 1 5", ok, dv_cyc_q.size());
      end
`ifdef UART_TX_FIFO_STATS_EN
      checks++;
      if (sent_cnt !== 16'd5 || drop_cnt !== 16'd2) begin
         errors++; $display("FAIL stats_counters: sent=%0d drop=%0d, need 5 2", sent_cnt, drop_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow_and_write_pop();
      test_reset_mid_frame();
      test_random();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch controller sitting directly upstream of uart_tx. It accepts bursts of bytes from the system side, stores them in a FIFO, and feeds uart_tx one byte at a time. Each byte is sent as a single-cycle o_Tx_Dv pulse, and the block obeys the transmitter's Active/Done sequencing so that no launch is ever issued while uart_tx cannot sample it.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..256.
- AW, $clog2(DEPTH): pointer width; derived, not overridden.

Ports:
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Wr_Dv  in  1  write strobe; one byte per cycle while high.
- i_Wr_Byte  in  8  write data.
- o_Full  out  1  FIFO holds DEPTH entries.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Count  out  AW+1  current occupancy, 0..DEPTH.
- o_Overflow  out  1  one-cycle pulse: a write was dropped.
- o_Tx_Dv  out  1  to uart_tx i_Tx_Dv; registered single-cycle pulse.
- o_Tx_Byte  out  8  to uart_tx i_Tx_Byte; registered, stable from the Dv cycle until the next launch.
- i_Tx_Active  in  1  from uart_tx o_Tx_Active.
- i_Tx_Done  in  1  from uart_tx o_Tx_Done (high for 2 cycles per frame).
- o_Busy  out  1  high when the state is not IDLE or o_Empty=0.

Behaviour:
- One clock domain: i_Clock. i_Reset is asynchronous and active-high; all state registers use it.
- Reset values:
  - Pointers and count are 0, so o_Empty=1, o_Full=0, o_Count=0.
  - o_Tx_Dv=0, o_Tx_Byte=8'h00, o_Overflow=0.
  - State is IDLE. FIFO contents are discarded; RAM itself is not cleared.
- Write:
  - Accepted when i_Wr_Dv=1 and o_Full=0, using the registered flag.
  - A write while o_Full=1 is dropped, even if a pop happens the same cycle; o_Overflow pulses on the next cycle.
- Flags: o_Count, o_Full and o_Empty are registered and update the cycle after a push or pop.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: when o_Empty=0 and i_Tx_Active=0 and i_Tx_Done=0, pop the head and load it into o_Tx_Byte. Set o_Tx_Dv<=1 and go to WAIT_ACT.
  - WAIT_ACT: o_Tx_Dv<=0, so Dv is exactly 1 cycle. Stay until i_Tx_Active=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until i_Tx_Done=1, then go to DRAIN.
  - DRAIN: stay until i_Tx_Done=0, then go to IDLE. At that point uart_tx is back in its IDLE state and samples the next Dv.
- Latency: for a write at cycle N into an empty FIFO with the transmitter idle:
  - Count becomes 1 at N+1.
  - o_Tx_Dv is high during N+2.
  - i_Tx_Active is high from N+3.
- Back-to-back: the next Dv is issued 2 cycles after i_Tx_Done falls, with no lost or duplicated bytes.
- Reset mid-frame: uart_tx has no reset and may still be transmitting. The IDLE guard (Active=0, Done=0) holds the next launch until that frame completes.
- The block does not time out. If uart_tx never asserts Active, the block waits in WAIT_ACT indefinitely.

Optional Feature:
UART_TX_FIFO_STATS_EN
- Defined:
  - Adds o_Sent_Cnt (16 bits), incremented on each WAIT_DONE to DRAIN transition.
  - Adds o_Drop_Cnt (16 bits), incremented on each dropped write.
  - Both counters saturate at 16'hFFFF and are cleared by i_Reset.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package uart_pkg holds:
  - the state encoding constants for IDLE, WAIT_ACT, WAIT_DONE and DRAIN (2 bits);
  - the byte width constant (8).
- One natural sub-module, sync_fifo:
  - parameterised storage, pointers, count and flags;
  - push/pop interface with registered flags.
- uart_tx_fifo instantiates sync_fifo plus the launch FSM.

Test Plan:
- Bench setup: uart_tx with CLKS_PER_BIT=4 is connected to the block's Tx ports.
- Reset, then write 8'hA5 once -> o_Tx_Dv high exactly 1 cycle at N+2, o_Tx_Byte=8'hA5, o_Count returns to 0, the serial line carries 0,1,0,1,0,0,1,0,1,1 (start bit, LSB-first data, stop bit).
- Burst-write 8'h01..8'h04 on consecutive cycles -> four frames in order, each Dv issued 2 cycles after Done falls, o_Busy low after the last DRAIN.
- DEPTH=4: write 6 bytes at a stalled transmitter (i_Tx_Active forced to 1) -> o_Full=1 after 4 writes, o_Overflow pulses twice, o_Count=4; the first four bytes are later sent intact.
- Write while full in the same cycle as a pop -> write dropped, o_Overflow=1, o_Count=3.
- Assert i_Reset mid-frame with 3 bytes queued -> o_Empty=1, o_Tx_Dv=0; the in-flight uart_tx frame completes; a byte written after reset launches only after Done falls.
- With UART_TX_FIFO_STATS_EN defined, send 5 bytes and drop 2 -> o_Sent_Cnt=5, o_Drop_Cnt=2.
